// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the multiply/divide unit
package cpu_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

    // Bit 0 of the op code is clear for the signed variants.
    function automatic logic mdu_is_signed(input logic [1:0] o);
        return ~o[0];
    endfunction

    // Bit 1 of the op code selects the divide datapath.
    function automatic logic mdu_is_div(input logic [1:0] o);
        return o[1];
    endfunction

endpackage

// File: rtl/mdu_32.sv
// rtl/mdu_32.sv - iterative 32-bit multiply/divide unit with HI/LO registers
module mdu_32
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic               res_signed;
    logic               res_neg;
    logic               div_zero;
    logic               start_signed;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_orig;

    // Operand magnitudes stay fixed during CALC; the counter picks the current bit.
    // Multiply: add the multiplicand into the upper half, then shift the accumulator right.
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (opb_q[cnt_q[4:0]] ? {1'b0, opa_q} : '0);

    // Divide: remainder lives in the upper half, quotient bits shift into the lower half.
    // The remainder is always below the divisor, so bit 32 of the trial difference is the borrow.
    assign div_part = {work_q[2*WIDTH-1:WIDTH], opa_q[~cnt_q[4:0]]};
    assign div_diff = div_part - {1'b0, opb_q};
    assign div_ok   = ~div_diff[WIDTH];
    assign div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];

    assign res_signed   = mdu_is_signed(op_q);
    assign res_neg      = res_signed & (sa_q ^ sb_q);
    assign div_zero     = (opb_q == '0);
    assign start_signed = mdu_is_signed(op);
    assign prod_fix     = res_neg ? -work_q : work_q;
    assign quot_fix     = res_neg ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    assign rem_fix      = (res_signed & sa_q) ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
    // Recover the original dividend for the divide-by-zero result.
    assign a_orig       = (res_signed & sa_q) ? -opa_q : opa_q;

    assign busy = (state_q != MDU_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Next-state, datapath step and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start && !flush) begin
                    state_d = MDU_CALC;
                    op_d    = mdu_op_e'(op);
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
                    opa_d   = (start_signed && a[WIDTH-1]) ? -a : a;
                    opb_d   = (start_signed && b[WIDTH-1]) ? -b : b;
                    cnt_d   = '0;
                    work_d  = '0;
                end else if (!start) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            MDU_CALC: begin
                if (flush) begin
                    state_d = MDU_IDLE;
                end else begin
                    if (mdu_is_div(op_q)) begin
                        work_d = {div_rem, work_q[WIDTH-2:0], div_ok};
                    end else begin
                        work_d = {mul_sum, work_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(ITER - 1)) state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                state_d = MDU_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (mdu_is_div(op_q)) begin
                        if (div_zero) begin
                            hi_d = a_orig;
                            lo_d = {WIDTH{1'b1}};
                        end else begin
                            hi_d = rem_fix;
                            lo_d = quot_fix;
                        end
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            op_q    <= MDU_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_mdu_32.sv
// tb/tb_mdu_32.sv - self-checking bench for mdu_32 against an arithmetic reference model
module tb_mdu_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mdu_32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference result {hi, lo} computed with plain integer arithmetic.
    function automatic logic [63:0] ref_mdu(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        int          sx, sy, q, r;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return 64'(sp);
            end
            2'b01: begin
                up = {32'h0, x} * {32'h0, y};
                return up;
            end
            2'b10: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sx = $signed(x);
                sy = $signed(y);
                q  = sx / sy;
                r  = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one operation and wait (bounded) for done; k = edges from start edge to result edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int k);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
        n_total++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  vo;
        logic [31:0] va, vb, eh, el;
        int k;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin vo = 2'b01; va = 32'hFFFF_FFFF; vb = 32'h2;         eh = 32'h1;         el = 32'hFFFF_FFFE; end
                1: begin vo = 2'b00; va = 32'hFFFF_FFFD; vb = 32'h7;         eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFEB; end
                2: begin vo = 2'b10; va = 32'hFFFF_FFF9; vb = 32'h2;         eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD; end
                3: begin vo = 2'b11; va = 32'h1234;      vb = 32'h0;         eh = 32'h1234;      el = 32'hFFFF_FFFF; end
                4: begin vo = 2'b10; va = 32'h8000_0000; vb = 32'hFFFF_FFFF; eh = 32'h0;         el = 32'h8000_0000; end
                default: begin vo = 2'b10; va = 32'hFFFF_FFFB; vb = 32'h0;   eh = 32'hFFFF_FFFB; el = 32'hFFFF_FFFF; end
            endcase
            run_op(vo, va, vb, k);
            n_total++; if (k != 33) $display("FAIL dir%0d_latency: got %0d want 33", i, k); else n_pass++;
            n_total++; if (hi !== eh) $display("FAIL dir%0d_hi: got %h want %h", i, hi, eh); else n_pass++;
            n_total++; if (lo !== el) $display("FAIL dir%0d_lo: got %h want %h", i, lo, el); else n_pass++;
            n_total++; if (busy !== 1'b0) $display("FAIL dir%0d_busy_at_done: got %b want 0", i, busy); else n_pass++;
            @(negedge clk);
            n_total++; if (done !== 1'b0) $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [1:0]  vo;
        logic [31:0] va, vb;
        logic [63:0] e;
        int k, mode;
        for (int i = 0; i < 40; i++) begin
            vo   = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 7);
            va   = $urandom;
            vb   = $urandom;
            if (mode == 0) vb = 32'h0;
            if (mode == 1) begin va = 32'h8000_0000; vb = 32'hFFFF_FFFF; end
            if (mode == 2) begin va = $urandom_range(0, 300); vb = $urandom_range(1, 20); end
            if (mode == 3) vb = vb >> $urandom_range(0, 31);
            e = ref_mdu(vo, va, vb);
            run_op(vo, va, vb, k);
            n_total++; if (k != 33) $display("FAIL rand%0d_latency: got %0d want 33", i, k); else n_pass++;
            n_total++; if (hi !== e[63:32]) $display("FAIL rand%0d_hi op=%0d a=%h b=%h: got %h want %h", i, vo, va, vb, hi, e[63:32]); else n_pass++;
            n_total++; if (lo !== e[31:0]) $display("FAIL rand%0d_lo op=%0d a=%h b=%h: got %h want %h", i, vo, va, vb, lo, e[31:0]); else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] e1, e2;
        int k;
        e1 = ref_mdu(2'b00, 32'h8765_4321, 32'h1357_9BDF);
        e2 = ref_mdu(2'b11, 32'hDEAD_BEEF, 32'h0000_1001);
        run_op(2'b00, 32'h8765_4321, 32'h1357_9BDF, k);
        n_total++; if (lo !== e1[31:0]) $display("FAIL b2b_first_lo: got %h want %h", lo, e1[31:0]); else n_pass++;
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1001, k);
        n_total++; if (k != 33) $display("FAIL b2b_latency: got %0d want 33", k); else n_pass++;
        n_total++; if (hi !== e2[63:32]) $display("FAIL b2b_hi: got %h want %h", hi, e2[63:32]); else n_pass++;
        n_total++; if (lo !== e2[31:0]) $display("FAIL b2b_lo: got %h want %h", lo, e2[31:0]); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        int seen;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55AA_55AA;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else n_pass++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        n_total++; if (seen != 0) $display("FAIL flush_no_done: got %0d done cycles want 0", seen); else n_pass++;
        n_total++; if (hi !== 32'h55AA_55AA) $display("FAIL flush_hi_kept: got %h want 55aa55aa", hi); else n_pass++;
        n_total++; if (lo !== 32'h55AA_55AA) $display("FAIL flush_lo_kept: got %h want 55aa55aa", lo); else n_pass++;
        flush = 1'b1; start = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL flush_idle_start: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_start_busy();
        logic [63:0] e;
        logic [31:0] hold_hi;
        int k;
        e = ref_mdu(2'b11, 32'd1000, 32'd7);
        hold_hi = hi;
        op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            if (k == 5) begin start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9; end
            if (k == 8) start = 1'b0;
            if (k == 10) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678; end
            if (k == 11) begin hi_we = 1'b0; lo_we = 1'b0; end
            if (k == 12) begin
                n_total++; if (hi !== hold_hi) $display("FAIL busy_write_ignored: got %h want %h", hi, hold_hi); else n_pass++;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        n_total++; if (k != 33) $display("FAIL busy_start_latency: got %0d want 33", k); else n_pass++;
        n_total++; if (hi !== e[63:32]) $display("FAIL busy_start_hi: got %h want %h", hi, e[63:32]); else n_pass++;
        n_total++; if (lo !== e[31:0]) $display("FAIL busy_start_lo: got %h want %h", lo, e[31:0]); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL busy_start_not_queued: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0F0F;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++; if (hi !== 32'h0) $display("FAIL rstmid_hi: got %h want 0", hi); else n_pass++;
        n_total++; if (lo !== 32'h0) $display("FAIL rstmid_lo: got %h want 0", lo); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        n_total++; if (seen != 0) $display("FAIL rstmid_no_done: got %0d done cycles want 0", seen); else n_pass++;
    endtask

    task automatic test_mtlo_start();
        logic [31:0] prev_lo;
        int k;
        prev_lo = lo;
        op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL mtlo_start_busy: got %b want 1", busy); else n_pass++;
        n_total++; if (lo !== prev_lo) $display("FAIL mtlo_start_dropped: got %h want %h", lo, prev_lo); else n_pass++;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_total++; if (k != 33) $display("FAIL mtlo_start_latency: got %0d want 33", k); else n_pass++;
        n_total++; if (lo !== 32'd15) $display("FAIL mtlo_start_lo: got %h want 0000000f", lo); else n_pass++;
        n_total++; if (hi !== 32'd0) $display("FAIL mtlo_start_hi: got %h want 0", hi); else n_pass++;
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hCAFE_0000;
        @(negedge clk);
        hi_we = 1'b0;
        n_total++; if (hi !== 32'hCAFE_0000) $display("FAIL mthi_hi: got %h want cafe0000", hi); else n_pass++;
        n_total++; if (lo !== 32'd15) $display("FAIL mthi_lo_kept: got %h want 0000000f", lo); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_start_busy();
        test_reset_mid();
        test_mtlo_start();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
